// File: rtl/macrocell_configuration_stream_decoder.sv
// macrocell_configuration_stream_decoder: serial macrocell config bits in, one decoded record per macrocell out
`timescale 1ns/1ps
module macrocell_configuration_stream_decoder #(
  parameter int num_labs = 2,
  parameter int macrocells_per_lab = 16,
  parameter int product_terms_per_macrocell = 5,
  parameter int bits_per_macrocell = 14,
  localparam int P = product_terms_per_macrocell,
  localparam int W = bits_per_macrocell,
  localparam int LW = (num_labs > 1) ? $clog2(num_labs) : 1,
  localparam int MW = (macrocells_per_lab > 1) ? $clog2(macrocells_per_lab) : 1,
  localparam int CW = $clog2(W)
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic          i_bit_in,
  input  logic          i_bit_valid,
  output logic          o_bit_ready,
  output logic          o_record_valid,
  input  logic          i_record_ready,
  output logic [LW-1:0] o_lab_index,
  output logic [MW-1:0] o_macrocell_index,
  output logic [P-1:0]  o_product_term_enable,
  output logic          o_clear_select,
  output logic          o_enable_preset,
  output logic [1:0]    o_clock_and_enable_switch,
  output logic          o_fast_input_select,
  output logic [2:0]    o_parallel_expander_enable,
  output logic          o_register_bypass_enable,
  output logic          o_busy,
  output logic          o_done
);
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_EMIT, S_DONE} state_t;
  state_t r_state, w_next;
  logic [W-1:0] r_sr;
  logic [CW-1:0] r_bit_count;
  logic [LW-1:0] r_lab;
  logic [MW-1:0] r_mc;
  logic w_bit_acc, w_rec_acc, w_last_bit, w_last_rec, w_clear;
  assign w_bit_acc = (r_state == S_SHIFT) && i_bit_valid;
  assign w_rec_acc = (r_state == S_EMIT) && i_record_ready;
  assign w_last_bit = r_bit_count == CW'(W - 1);
  assign w_last_rec = (r_lab == LW'(num_labs - 1)) && (r_mc == MW'(macrocells_per_lab - 1));
  assign w_clear = i_abort || (r_state == S_IDLE && i_start) || r_state == S_DONE;
  assign o_lab_index = r_lab;
  assign o_macrocell_index = r_mc;
  assign o_product_term_enable = r_sr[P-1:0];
  assign o_clear_select = r_sr[P];
  assign o_enable_preset = r_sr[P+1];
  assign o_clock_and_enable_switch = r_sr[P+3:P+2];
  assign o_fast_input_select = r_sr[P+4];
  assign o_parallel_expander_enable = r_sr[P+7:P+5];
  assign o_register_bypass_enable = r_sr[P+8];
  // state register
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) r_state <= S_IDLE;
    else r_state <= w_next;
  // next state and handshake outputs; abort overrides every transition
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_SHIFT;
      S_SHIFT: if (w_bit_acc && w_last_bit) w_next = S_EMIT;
      S_EMIT:  if (w_rec_acc) w_next = w_last_rec ? S_DONE : S_SHIFT;
      default: w_next = S_IDLE;
    endcase
    if (i_abort) w_next = S_IDLE;
    o_bit_ready = r_state == S_SHIFT;
    o_record_valid = r_state == S_EMIT;
    o_busy = r_state != S_IDLE;
    o_done = r_state == S_DONE;
  end
  // shift register, bit counter and record indices; the shift register holds the record during EMIT
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      r_sr <= '0;
      r_bit_count <= '0;
      r_lab <= '0;
      r_mc <= '0;
    end else if (w_clear) begin
      r_sr <= '0;
      r_bit_count <= '0;
      r_lab <= '0;
      r_mc <= '0;
    end else if (w_bit_acc) begin
      r_sr <= {i_bit_in, r_sr[W-1:1]};
      r_bit_count <= w_last_bit ? '0 : r_bit_count + 1'b1;
    end else if (w_rec_acc && !w_last_rec) begin
      r_bit_count <= '0;
      r_mc <= (r_mc == MW'(macrocells_per_lab - 1)) ? '0 : r_mc + 1'b1;
      r_lab <= (r_mc == MW'(macrocells_per_lab - 1)) ? r_lab + 1'b1 : r_lab;
    end
endmodule

// File: tb/tb_macrocell_configuration_stream_decoder.sv
// tb_macrocell_configuration_stream_decoder: randomized directed checks of the stream decoder against a field-arithmetic model
`timescale 1ns/1ps
module tb_macrocell_configuration_stream_decoder;
  logic clk = 0, rst = 1, start = 0, abort = 0, bit_in = 0, bit_valid = 0, record_ready = 0;
  logic bit_ready, record_valid, cs, ep, fis, rbe, busy, done;
  logic lab_index;
  logic [3:0] macrocell_index;
  logic [4:0] pte;
  logic [1:0] ces;
  logic [2:0] pee;
  logic [13:0] v;
  int vectors = 0, miscompares = 0;
  macrocell_configuration_stream_decoder dut (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_abort(abort),
    .i_bit_in(bit_in), .i_bit_valid(bit_valid), .o_bit_ready(bit_ready),
    .o_record_valid(record_valid), .i_record_ready(record_ready),
    .o_lab_index(lab_index), .o_macrocell_index(macrocell_index),
    .o_product_term_enable(pte), .o_clear_select(cs), .o_enable_preset(ep),
    .o_clock_and_enable_switch(ces), .o_fast_input_select(fis),
    .o_parallel_expander_enable(pee), .o_register_bypass_enable(rbe),
    .o_busy(busy), .o_done(done)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic do_start;
    start = 1;
    step;
    start = 0;
    chk("busy_after_start", busy, 1);
    chk("bit_ready_after_start", bit_ready, 1);
  endtask
  task automatic send(input logic [13:0] d, input bit gaps, input int nb);
    for (int i = 0; i < nb; i++) begin
      chk("bit_ready_shift", bit_ready, 1);
      chk("no_record_in_shift", record_valid, 0);
      bit_in = d[i];
      bit_valid = 1;
      start = $urandom_range(0, 5) == 0;
      step;
      start = 0;
      bit_valid = 0;
      if (gaps && i < nb - 1) begin
        bit_in = 1'($urandom);
        step;
      end
    end
  endtask
  task automatic expect_rec(input logic [13:0] d, input int n);
    chk("record_valid", record_valid, 1);
    chk("bit_ready_emit", bit_ready, 0);
    chk("lab_index", lab_index, n / 16);
    chk("macrocell_index", macrocell_index, n % 16);
    chk("product_term_enable", pte, d % 32);
    chk("clear_select", cs, (d / 32) % 2);
    chk("enable_preset", ep, (d / 64) % 2);
    chk("clock_and_enable_switch", ces, (d / 128) % 4);
    chk("fast_input_select", fis, (d / 512) % 2);
    chk("parallel_expander_enable", pee, (d / 1024) % 8);
    chk("register_bypass_enable", rbe, (d / 8192) % 2);
  endtask
  task automatic handshake(input logic [13:0] d, input int n, input int stall);
    for (int s = 0; s < stall; s++) begin
      bit_valid = s[0];
      bit_in = 1'($urandom);
      step;
      expect_rec(d, n);
    end
    bit_valid = 0;
    record_ready = 1;
    step;
    record_ready = 0;
    chk("record_valid_dropped", record_valid, 0);
    chk("done", done, n == 31);
    chk("busy_after_handshake", busy, 1);
    if (n == 31) begin
      step;
      chk("done_one_cycle", done, 0);
      chk("idle_after_done", busy, 0);
      chk("lab_index_cleared", lab_index, 0);
      chk("macrocell_index_cleared", macrocell_index, 0);
    end
  endtask
  initial begin
    step;
    step;
    chk("reset_busy", busy, 0);
    chk("reset_bit_ready", bit_ready, 0);
    chk("reset_record_valid", record_valid, 0);
    chk("reset_done", done, 0);
    chk("reset_fields", {rbe, pee, fis, ces, ep, cs, pte}, 0);
    chk("reset_indices", {lab_index, macrocell_index}, 0);
    rst = 0;
    step;
    step;
    chk("idle_no_bit_ready", bit_ready, 0);
    do_start;
    for (int n = 0; n < 32; n++) begin
      v = (n == 0) ? 14'b1_011_0_10_1_0_10101 : (n == 1) ? 14'h0000 : 14'($urandom);
      send(v, n == 1 || n == 5 || n == 20, 14);
      expect_rec(v, n);
      if (n == 0) chk("record0_fields", {rbe, pee, fis, ces, ep, cs, pte}, 14'b1_011_0_10_1_0_10101);
      handshake(v, n, (n == 2 || n == 17) ? 5 : $urandom_range(0, 2));
    end
    do_start;
    v = 14'($urandom);
    send(v, 0, 7);
    #2 rst = 1;
    #1;
    chk("async_reset_busy", busy, 0);
    chk("async_reset_bit_ready", bit_ready, 0);
    chk("async_reset_fields", {rbe, pee, fis, ces, ep, cs, pte}, 0);
    step;
    rst = 0;
    step;
    step;
    chk("post_reset_needs_start", bit_ready, 0);
    do_start;
    for (int n = 0; n < 3; n++) begin
      v = 14'($urandom);
      send(v, 0, 14);
      expect_rec(v, n);
      handshake(v, n, 0);
    end
    v = 14'($urandom);
    send(v, 0, 9);
    abort = 1;
    bit_valid = 1;
    bit_in = 1;
    step;
    abort = 0;
    bit_valid = 0;
    chk("abort_busy", busy, 0);
    chk("abort_record_valid", record_valid, 0);
    chk("abort_bit_ready", bit_ready, 0);
    chk("abort_no_done", done, 0);
    step;
    chk("abort_stays_idle", busy, 0);
    do_start;
    v = 14'($urandom);
    send(v, 0, 14);
    expect_rec(v, 0);
    abort = 1;
    record_ready = 1;
    start = 1;
    step;
    abort = 0;
    record_ready = 0;
    start = 0;
    chk("abort_over_handshake_busy", busy, 0);
    chk("abort_over_handshake_done", done, 0);
    chk("abort_over_handshake_valid", record_valid, 0);
    do_start;
    v = 14'($urandom);
    send(v, 1, 14);
    expect_rec(v, 0);
    handshake(v, 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
